// File: rtl/tag_rx_pkg.sv
// Shared definitions for the tag anchor receive scheduler: state encoding and
// front-panel GPIO bit positions.
package tag_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC_N = 3'd1,
        ST_SYNC_P = 3'd2,
        ST_SIG    = 3'd3,
        ST_DONE   = 3'd4
    } rx_state_e;

    localparam int         GPIO_START_BIT = 0;
    localparam int         GPIO_STATE_LSB = 0;
    localparam int         GPIO_TRIG_BIT  = 3;
    localparam logic [3:0] GPIO_DDR_LOW   = 4'hF;

endpackage

// File: rtl/tag_phase_acc.sv
// DDS phase accumulator: adds or subtracts a caller-selected increment,
// wrapping modulo 2^PHASE_WIDTH.
module tag_phase_acc #(
    parameter int PHASE_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   sub,
    input  logic [PHASE_WIDTH-1:0] inc,
    output logic [PHASE_WIDTH-1:0] ph
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph <= '0;
        end else if (clr) begin
            ph <= '0;
        end else if (en) begin
            ph <= sub ? ph - inc : ph + inc;
        end
    end

endmodule

// File: rtl/tag_rx_sched.sv
// Receive scheduler: sequences sync-negative, sync-positive and signal windows
// per location and drives the channel-hopping DDS phase word.
module tag_rx_sched
    import tag_rx_pkg::*;
#(
    parameter int PHASE_WIDTH = 24,
    parameter int NSYMB_WIDTH = 16,
    parameter int NSYNCN      = 16384,
    parameter int NSYNCP      = 16384,
    parameter int NSIG        = 262144,
    parameter int NSYMB       = 1,
    parameter int NLOC        = 3,
    parameter int NCH         = 4,
    parameter int REG_WIDTH   = 12
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  run_rx,
    input  logic                                  single_shot,
    input  logic                                  ext_start_en,
    input  logic                                  sample_valid,
    input  logic [PHASE_WIDTH-1:0]                ph_inc_base,
    input  logic [PHASE_WIDTH-1:0]                ph_inc_step,
    input  logic [REG_WIDTH-1:0]                  fp_gpio_in,
    output logic [2:0]                            rx_state,
    output logic [PHASE_WIDTH-1:0]                ph,
    output logic [$clog2(NSIG)-1:0]               sigN,
    output logic [NSYMB_WIDTH-1:0]                symbN,
    output logic [$clog2(NLOC+1)-1:0]             loc_idx,
    output logic [$clog2(NCH+1)-1:0]              chan_idx,
    output logic [$clog2(NSYNCN+NSYNCP+1)-1:0]    sync_count,
    output logic                                  rx_valid,
    output logic                                  rx_trig,
    output logic [REG_WIDTH-1:0]                  fp_gpio_out,
    output logic [REG_WIDTH-1:0]                  fp_gpio_ddr
);

    localparam int SIG_W  = $clog2(NSIG);
    localparam int LOC_W  = $clog2(NLOC+1);
    localparam int CHAN_W = $clog2(NCH+1);
    localparam int SYNC_W = $clog2(NSYNCN+NSYNCP+1);

    localparam logic [SIG_W-1:0]       SIG_LAST   = SIG_W'(NSIG-1);
    localparam logic [NSYMB_WIDTH-1:0] SYMB_LAST  = NSYMB_WIDTH'(NSYMB-1);
    localparam logic [LOC_W-1:0]       LOC_LAST   = LOC_W'(NLOC-1);
    localparam logic [CHAN_W-1:0]      CH_LAST    = CHAN_W'(NCH-1);
    localparam logic [SYNC_W-1:0]      SYNCN_LAST = SYNC_W'(NSYNCN-1);
    localparam logic [SYNC_W-1:0]      SYNC_LAST  = SYNC_W'(NSYNCN+NSYNCP-1);

    rx_state_e              state_q;
    logic [PHASE_WIDTH-1:0] cur_inc;
    logic                   gpio_p0, gpio_p1, gpio_p2;
    logic                   gpio_rise;
    logic                   gpio_unused;
    logic                   ph_en;

    // External start: two-flop synchroniser plus one flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gpio_p0 <= 1'b0;
            gpio_p1 <= 1'b0;
            gpio_p2 <= 1'b0;
        end else begin
            gpio_p0 <= fp_gpio_in[GPIO_START_BIT];
            gpio_p1 <= gpio_p0;
            gpio_p2 <= gpio_p1;
        end
    end

    assign gpio_rise   = gpio_p1 & ~gpio_p2;
    assign gpio_unused = ^fp_gpio_in[REG_WIDTH-1:1];

    assign ph_en = run_rx && sample_valid &&
                   (state_q == ST_SYNC_N || state_q == ST_SYNC_P || state_q == ST_SIG);

    tag_phase_acc #(
        .PHASE_WIDTH (PHASE_WIDTH)
    ) u_phase_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (!run_rx),
        .en      (ph_en),
        .sub     (state_q == ST_SYNC_N),
        .inc     ((state_q == ST_SIG) ? cur_inc : ph_inc_base),
        .ph      (ph)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sigN       <= '0;
            symbN      <= '0;
            loc_idx    <= '0;
            chan_idx   <= '0;
            sync_count <= '0;
            cur_inc    <= '0;
            rx_valid   <= 1'b0;
            rx_trig    <= 1'b0;
        end else begin
            rx_trig  <= 1'b0;
            rx_valid <= run_rx && sample_valid && (state_q == ST_SIG);
            if (!run_rx) begin
                state_q    <= ST_IDLE;
                sigN       <= '0;
                symbN      <= '0;
                loc_idx    <= '0;
                chan_idx   <= '0;
                sync_count <= '0;
                cur_inc    <= ph_inc_base;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cur_inc <= ph_inc_base;
                        if (!ext_start_en || gpio_rise) state_q <= ST_SYNC_N;
                    end
                    ST_SYNC_N: if (sample_valid) begin
                        sync_count <= sync_count + 1'b1;
                        if (sync_count == SYNCN_LAST) state_q <= ST_SYNC_P;
                    end
                    ST_SYNC_P: if (sample_valid) begin
                        if (sync_count == SYNC_LAST) begin
                            state_q    <= ST_SIG;
                            sync_count <= '0;
                            rx_trig    <= 1'b1;
                        end else begin
                            sync_count <= sync_count + 1'b1;
                        end
                    end
                    ST_SIG: if (sample_valid) begin
                        if (sigN == SIG_LAST) begin
                            sigN <= '0;
                            // Increment tracks base + chan*step by accumulation, reloading on wrap
                            if (chan_idx == CH_LAST) begin
                                chan_idx <= '0;
                                cur_inc  <= ph_inc_base;
                            end else begin
                                chan_idx <= chan_idx + 1'b1;
                                cur_inc  <= cur_inc + ph_inc_step;
                            end
                            if (symbN == SYMB_LAST) begin
                                symbN <= '0;
                                if (loc_idx == LOC_LAST) begin
                                    if (single_shot) begin
                                        state_q <= ST_DONE;
                                        loc_idx <= loc_idx + 1'b1;
                                    end else begin
                                        state_q <= ST_SYNC_N;
                                        loc_idx <= '0;
                                    end
                                end else begin
                                    loc_idx <= loc_idx + 1'b1;
                                    rx_trig <= 1'b1;
                                end
                            end else begin
                                symbN <= symbN + 1'b1;
                            end
                        end else begin
                            sigN <= sigN + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx_state = state_q;

    always_comb begin
        fp_gpio_out                         = '0;
        fp_gpio_out[GPIO_STATE_LSB +: 3]    = state_q;
        fp_gpio_out[GPIO_TRIG_BIT]          = rx_trig;
    end

    assign fp_gpio_ddr = REG_WIDTH'(GPIO_DDR_LOW);

endmodule

// File: tb/tb_tag_rx_sched.sv
// Bench for tag_rx_sched: fixed checkpoint table, corner-case sequences and
// randomised sample_valid against a window-position reference model.
module tb_tag_rx_sched;

    localparam int PW     = 8;
    localparam int NSYNCN = 4;
    localparam int NSYNCP = 4;
    localparam int NSIG   = 8;
    localparam int NSYMB  = 2;
    localparam int NLOC   = 3;
    localparam int NCH    = 4;
    localparam int RW     = 12;
    localparam int SYNC   = NSYNCN + NSYNCP;
    localparam int PERIOD = SYNC + NLOC * NSYMB * NSIG;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          run_rx = 1'b0, single_shot = 1'b0, ext_start_en = 1'b0, sample_valid = 1'b0;
    logic [PW-1:0] ph_inc_base = 8'h10, ph_inc_step = 8'h04;
    logic [RW-1:0] fp_gpio_in = '0;
    logic [2:0]    rx_state;
    logic [PW-1:0] ph;
    logic [2:0]    sigN;
    logic [15:0]   symbN;
    logic [1:0]    loc_idx;
    logic [2:0]    chan_idx;
    logic [3:0]    sync_count;
    logic          rx_valid, rx_trig;
    logic [RW-1:0] fp_gpio_out, fp_gpio_ddr;

    tag_rx_sched #(
        .PHASE_WIDTH(PW), .NSYMB_WIDTH(16), .NSYNCN(NSYNCN), .NSYNCP(NSYNCP),
        .NSIG(NSIG), .NSYMB(NSYMB), .NLOC(NLOC), .NCH(NCH), .REG_WIDTH(RW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .run_rx(run_rx), .single_shot(single_shot),
        .ext_start_en(ext_start_en), .sample_valid(sample_valid),
        .ph_inc_base(ph_inc_base), .ph_inc_step(ph_inc_step), .fp_gpio_in(fp_gpio_in),
        .rx_state(rx_state), .ph(ph), .sigN(sigN), .symbN(symbN), .loc_idx(loc_idx),
        .chan_idx(chan_idx), .sync_count(sync_count), .rx_valid(rx_valid), .rx_trig(rx_trig),
        .fp_gpio_out(fp_gpio_out), .fp_gpio_ddr(fp_gpio_ddr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int trig_seen = 0;

    // Reference model: run mode plus number of samples consumed since start
    typedef enum int {M_IDLE, M_ACT, M_DONE} mmode_e;
    mmode_e m_mode = M_IDLE;
    int     m_k = 0;
    int     m_ph = 0;
    bit     m_valid = 0, m_trig = 0;
    bit [3:0] hist = '0;

    typedef struct {
        int adv; int st; int ph; int chan; int loc; int trig;
    } rec_t;
    rec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sym_done(input int k);
        int r = k % PERIOD;
        return (k / PERIOD) * NLOC * NSYMB + ((r >= SYNC) ? (r - SYNC) / NSIG : 0);
    endfunction

    function automatic int inc_at(input int k);
        int r = k % PERIOD;
        if (r < NSYNCN) return -int'(ph_inc_base);
        if (r < SYNC)   return int'(ph_inc_base);
        return int'(ph_inc_base) + (sym_done(k) % NCH) * int'(ph_inc_step);
    endfunction

    function automatic bit is_loc_start(input int k);
        int r = k % PERIOD;
        for (int l = 0; l < NLOC; l++)
            if (r == SYNC + l * NSYMB * NSIG) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_model();
        int e_st = 0, e_sig = 0, e_sym = 0, e_loc = 0, e_ch = 0, e_sync = 0;
        int r = m_k % PERIOD;
        if (m_mode != M_IDLE) begin
            e_ch = sym_done(m_k) % NCH;
            if (m_mode == M_DONE) begin
                e_st = 4; e_loc = NLOC;
            end else if (r < NSYNCN) begin
                e_st = 1; e_sync = r;
            end else if (r < SYNC) begin
                e_st = 2; e_sync = r;
            end else begin
                e_st  = 3;
                e_sig = (r - SYNC) % NSIG;
                e_sym = ((r - SYNC) / NSIG) % NSYMB;
                e_loc = (r - SYNC) / (NSIG * NSYMB);
            end
        end
        chk("rx_state", int'(rx_state), e_st);
        chk("ph", int'(ph), m_ph & 8'hFF);
        chk("sigN", int'(sigN), e_sig);
        chk("symbN", int'(symbN), e_sym);
        chk("loc_idx", int'(loc_idx), e_loc);
        chk("chan_idx", int'(chan_idx), e_ch);
        chk("sync_count", int'(sync_count), e_sync);
        chk("rx_valid", int'(rx_valid), int'(m_valid));
        chk("rx_trig", int'(rx_trig), int'(m_trig));
        chk("fp_gpio_out", int'(fp_gpio_out), int'(m_trig) * 8 + e_st);
        chk("fp_gpio_ddr", int'(fp_gpio_ddr), 12'h00F);
    endtask

    // One clock: drive inputs, advance the model, check at the falling edge
    task automatic step(input bit run, input bit sv);
        bit rise;
        run_rx = run;
        sample_valid = sv;
        hist = {hist[2:0], fp_gpio_in[0]};
        rise = hist[2] && !hist[3];
        m_valid = run && sv && (m_mode == M_ACT) && ((m_k % PERIOD) >= SYNC);
        m_trig = 1'b0;
        if (!run) begin
            m_mode = M_IDLE; m_k = 0; m_ph = 0;
        end else if (m_mode == M_IDLE) begin
            if (!ext_start_en || rise) begin
                m_mode = M_ACT; m_k = 0; m_ph = 0;
            end
        end else if (m_mode == M_ACT && sv) begin
            m_ph = (m_ph + inc_at(m_k)) & 8'hFF;
            m_k++;
            if (single_shot && (m_k % PERIOD == 0)) m_mode = M_DONE;
            else if (is_loc_start(m_k)) m_trig = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        if (rx_trig) trig_seen++;
        check_model();
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_k = 0; m_ph = 0; m_valid = 0; m_trig = 0; hist = '0;
    endtask

    initial begin
        tbl[0]  = '{1, 1, 8'h00, 0, 0, 0};
        tbl[1]  = '{4, 2, 8'hC0, 0, 0, 0};
        tbl[2]  = '{4, 3, 8'h00, 0, 0, 1};
        tbl[3]  = '{8, 3, 8'h80, 1, 0, 0};
        tbl[4]  = '{8, 3, 8'h20, 2, 1, 1};
        tbl[5]  = '{8, 3, 8'hE0, 3, 1, 0};
        tbl[6]  = '{8, 3, 8'hC0, 0, 2, 1};
        tbl[7]  = '{8, 3, 8'h40, 1, 2, 0};
        tbl[8]  = '{8, 1, 8'hE0, 2, 0, 0};
        tbl[9]  = '{4, 2, 8'hA0, 2, 0, 0};
        tbl[10] = '{4, 3, 8'hE0, 2, 0, 1};
        tbl[11] = '{8, 3, 8'hA0, 3, 0, 0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_model();
        reset_n = 1'b1;
        model_reset();
        step(0, 0);

        // Continuous run against fixed checkpoints
        trig_seen = 0;
        for (int i = 0; i < 12; i++) begin
            repeat (tbl[i].adv) step(1, 1);
            chk($sformatf("tbl%0d_state", i), int'(rx_state), tbl[i].st);
            chk($sformatf("tbl%0d_ph", i), int'(ph), tbl[i].ph);
            chk($sformatf("tbl%0d_chan", i), int'(chan_idx), tbl[i].chan);
            chk($sformatf("tbl%0d_loc", i), int'(loc_idx), tbl[i].loc);
            chk($sformatf("tbl%0d_trig", i), int'(rx_trig), tbl[i].trig);
            if (i == 8) chk("trig_per_cycle", trig_seen, 3);
        end

        // Randomised sample_valid and increments, occasional aborts
        for (int n = 0; n < 4; n++) begin
            step(0, 0);
            ph_inc_base = 8'($urandom_range(0, 255));
            ph_inc_step = 8'($urandom_range(0, 255));
            for (int i = 0; i < 150; i++)
                step(($urandom_range(0, 79) != 0), 1'($urandom_range(0, 1)));
        end
        step(0, 0);
        ph_inc_base = 8'h10;
        ph_inc_step = 8'h04;

        // Single-shot with sample_valid toggling every cycle
        single_shot = 1'b1;
        step(1, 0);
        for (int i = 0; i < 2 * PERIOD; i++) step(1, (i % 2) == 0);
        chk("ss_done_state", int'(rx_state), 4);
        chk("ss_done_ph", int'(ph), 8'hE0);
        for (int i = 0; i < 6; i++) step(1, 1'($urandom_range(0, 1)));
        chk("ss_hold_state", int'(rx_state), 4);
        chk("ss_hold_ph", int'(ph), 8'hE0);
        step(0, 0);
        chk("ss_abort_state", int'(rx_state), 0);
        chk("ss_abort_ph", int'(ph), 0);
        chk("ss_abort_gpio", int'(fp_gpio_out), 0);
        single_shot = 1'b0;

        // External start
        ext_start_en = 1'b1;
        repeat (3) step(1, 0);
        chk("ext_wait_state", int'(rx_state), 0);
        fp_gpio_in[0] = 1'b1;
        step(1, 0);
        step(1, 0);
        chk("ext_lat2_state", int'(rx_state), 0);
        step(1, 0);
        chk("ext_lat3_state", int'(rx_state), 1);
        repeat (3) step(1, 1);
        ext_start_en = 1'b0;
        fp_gpio_in[0] = 1'b0;
        step(0, 0);

        // Abort mid-SIG at location 1, sigN 5
        repeat (30) step(1, 1);
        chk("mid_sig_loc", int'(loc_idx), 1);
        chk("mid_sig_sigN", int'(sigN), 5);
        step(0, 1);
        chk("abort_state", int'(rx_state), 0);
        chk("abort_ph", int'(ph), 0);
        chk("abort_trig", int'(rx_trig), 0);
        chk("abort_valid", int'(rx_valid), 0);

        // Asynchronous reset mid-SYNC_P
        repeat (6) step(1, 1);
        chk("pre_rst_state", int'(rx_state), 2);
        reset_n = 1'b0;
        #1;
        chk("arst_state", int'(rx_state), 0);
        chk("arst_ph", int'(ph), 0);
        chk("arst_sync", int'(sync_count), 0);
        chk("arst_gpio", int'(fp_gpio_out), 0);
        chk("arst_ddr", int'(fp_gpio_ddr), 12'h00F);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 0);
        step(1, 1);
        step(1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tag_rx_sched.md
# tag_rx_sched

Parametrised multi-location, multi-channel receive scheduler for the tag anchor RX path. It sequences sync-negative, sync-positive and signal windows per location. It generates the DDS phase word, with channel hopping per symbol, that the downstream sin/cos and baseband mixer consume. It supports continuous and single-shot modes plus an optional GPIO-triggered start, and exports state and trigger on the front-panel GPIO.

## Interface
- PHASE_WIDTH, 24, DDS phase accumulator width
- NSYMB_WIDTH, 16, symbol counter width
- NSYNCN, 16384, samples in negative-tone sync window
- NSYNCP, 16384, samples in positive-tone sync window
- NSIG, 262144, samples per symbol in signal window
- NSYMB, 1, symbols per location
- NLOC, 3, locations per sync cycle
- NCH, 4, hop channels (≥1)
- REG_WIDTH, 12, GPIO width (≥4)

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- run_rx  in  1  enable; deassert aborts to IDLE
- single_shot  in  1  1 = stop in DONE after NLOC locations
- ext_start_en  in  1  1 = wait for GPIO edge before starting
- sample_valid  in  1  advances all counters and the phase
- ph_inc_base  in  PHASE_WIDTH  base tone increment
- ph_inc_step  in  PHASE_WIDTH  per-channel increment step
- fp_gpio_in  in  REG_WIDTH  bit 0 = external start (asynchronous)
- rx_state  out  3  IDLE=0, SYNC_N=1, SYNC_P=2, SIG=3, DONE=4
- ph  out  PHASE_WIDTH  phase word
- sigN  out  $clog2(NSIG)  sample index within symbol
- symbN  out  NSYMB_WIDTH  symbol index within location
- loc_idx  out  $clog2(NLOC+1)  location index
- chan_idx  out  $clog2(NCH+1)  current channel
- sync_count  out  $clog2(NSYNCN+NSYNCP+1)  sync sample count
- rx_valid  out  1  registered sample_valid while in SIG
- rx_trig  out  1  one-cycle pulse on entering each location's SIG window
- fp_gpio_out  out  REG_WIDTH  {0…, rx_trig, rx_state}
- fp_gpio_ddr  out  REG_WIDTH  constant; low 4 bits = 1

## Operation
- IDLE: counters, ph and chan_idx are 0. Start condition:
  - ext_start_en=0: run_rx=1 starts SYNC_N.
  - ext_start_en=1: needs run_rx=1 and a rising edge on fp_gpio_in[0], double-flop synchronised.
- SYNC_N: ph -= ph_inc_base on each sample_valid. sync_count counts 0..NSYNCN-1. On the last sample, go to SYNC_P.
- SYNC_P: ph += ph_inc_base. sync_count continues NSYNCN..NSYNCN+NSYNCP-1. On the last sample, go to SIG with loc_idx=0.
- SIG: ph += cur_inc.
  - cur_inc = ph_inc_base + chan_idx*ph_inc_step, held in a register; no multiplier.
  - sigN counts to NSIG-1, then sigN=0, symbN++, and chan_idx = (chan_idx+1) mod NCH. On a channel wrap, cur_inc reloads base; otherwise cur_inc += step.
  - After NSYMB symbols: symbN=0, loc_idx++.
  - After NLOC locations: go to DONE if single_shot, else SYNC_N. chan_idx persists across locations; ph is continuous.
- DONE: hold. run_rx=0 returns to IDLE.
- run_rx=0 in any state: IDLE on the next clock, all counters cleared, no rx_trig.
- Arithmetic: all phase math is modulo 2^PHASE_WIDTH with silent wrap. ph_inc_* are sampled on every use.

## Timing
- Every output is registered; reset value is 0 except fp_gpio_ddr.
- Counter, ph and state updates appear one cycle after the qualifying sample_valid.
- With sample_valid=0, all state is held.
- rx_trig asserts in the first cycle rx_state=3 for each location, including back-to-back locations.
- rx_valid equals sample_valid delayed one cycle, gated by SIG.
- External start latency: three cycles from the fp_gpio_in[0] rise to rx_state=1.
- Reset is asynchronous assert and synchronous deassert, handled outside the block.

## Structure
- Package tag_rx_pkg: state encoding constants and GPIO bit positions.
- Sub-module tag_phase_acc: phase register with add/sub of a selectable increment.
- The FSM and counters live in the top module.

## Test plan
Bench parameters: NSYNCN=4, NSYNCP=4, NSIG=8, NSYMB=2, NLOC=3, NCH=4, PHASE_WIDTH=8, base=0x10, step=0x04.
1. Continuous run, sample_valid always 1 → states 1,2,3 for 4, 4 and 48 cycles, then back to 1. ph after SYNC_N = 0xC0, after SYNC_P = 0x00. rx_trig pulses 3 times per cycle.
2. Channel hop → per-symbol increments 0x10, 0x14, 0x18, 0x1C, 0x10, … with chan_idx 0,1,2,3,0 across locations. ph wraps at 0x100.
3. single_shot=1 → rx_state=4 after 56 valid samples, outputs hold. run_rx=0 → IDLE, all outputs 0.
4. sample_valid toggling 1/0 → same count sequence over 2× the cycles. rx_valid mirrors the gaps.
5. ext_start_en=1 with run_rx=1 → stays IDLE until fp_gpio_in[0] rises, then rx_state=1 three cycles later.
6. run_rx dropped mid-SIG (loc 1, sigN=5) → IDLE next cycle. Async reset_n low mid-SYNC_P → all outputs 0 immediately.
